// File: rtl/seg_scan_if.sv
// seg_scan_if: decoder-side inputs and display-side outputs of the six-digit scanner.
interface seg_scan_if;
    logic [41:0] seg_in;
    logic [1:0]  mode;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    modport master (output seg_in, mode, input an, seg, dp, frame_tick);
    modport slave  (input seg_in, mode, output an, seg, dp, frame_tick);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed HH:MM:SS scanner with anode guard band,
// per-frame input snapshot and blinking of the field being edited.
module seg_scan_driver #(
    parameter int DIGIT_TICKS    = 50000,
    parameter int GUARD_TICKS    = 500,
    parameter int BLINK_TICKS    = 12500000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave disp_io
);
    localparam int CW = $clog2(DIGIT_TICKS);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] GUARD      = CW'(GUARD_TICKS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [41:0]   shadow_q, shadow_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ph_q, ph_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d, tick_q;
    logic          wrap, frame, bwrap, sel, blank;
    logic [1:0]    fld;
    logic [5:0]    base;

    always_comb begin
        wrap     = cnt_q == CNT_LAST;
        frame    = wrap && idx_q == 3'd5;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? (idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1) : idx_q;
        shadow_d = frame ? disp_io.seg_in : shadow_q;
        bwrap    = bcnt_q == BLINK_LAST;
        bcnt_d   = (disp_io.mode == 2'd0 || bwrap) ? '0 : bcnt_q + 1'b1;
        ph_d     = disp_io.mode == 2'd0 ? 1'b0 : ph_q ^ bwrap;
        sel      = cnt_q >= GUARD;
        // field code of the current digit matches the mode that edits it
        fld      = idx_q >= 3'd4 ? 2'd1 : idx_q >= 3'd2 ? 2'd2 : 2'd3;
        blank    = ph_q && disp_io.mode == fld;
        base     = 6'(idx_q) * 6'd7;
        seg_d    = blank ? 7'd0 : shadow_q[base +: 7];
        an_d     = sel ? 6'd1 << idx_q : 6'd0;
        dp_d     = sel && (idx_q == 3'd2 || idx_q == 3'd4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            bcnt_q   <= '0;
            ph_q     <= 1'b0;
            an_q     <= {6{AN_ACTIVE_LOW}};
            seg_q    <= {7{SEG_ACTIVE_LOW}};
            dp_q     <= SEG_ACTIVE_LOW;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            bcnt_q   <= bcnt_d;
            ph_q     <= ph_d;
            an_q     <= an_d ^ {6{AN_ACTIVE_LOW}};
            seg_q    <= seg_d ^ {7{SEG_ACTIVE_LOW}};
            dp_q     <= dp_d ^ SEG_ACTIVE_LOW;
            tick_q   <= frame;
        end
    end

    assign disp_io.an         = an_q;
    assign disp_io.seg        = seg_q;
    assign disp_io.dp         = dp_q;
    assign disp_io.frame_tick = tick_q;
endmodule
